// File: rtl/sub_bytes_sched_if.sv
// Request/result bundle between the S-box scheduler and its two requesters
// (round datapath and key expansion).
interface sub_bytes_sched_if;
   logic         rnd_req;
   logic         rnd_inv;
   logic [0:127] rnd_state;
   logic         rnd_ack;
   logic         rnd_done;
   logic [0:127] rnd_result;
   logic         key_req;
   logic [0:31]  key_word;
   logic         key_ack;
   logic         key_done;
   logic [0:31]  key_result;
   logic         busy;

   modport master (
      output rnd_req, rnd_inv, rnd_state, key_req, key_word,
      input  rnd_ack, rnd_done, rnd_result, key_ack, key_done, key_result, busy
   );

   modport slave (
      input  rnd_req, rnd_inv, rnd_state, key_req, key_word,
      output rnd_ack, rnd_done, rnd_result, key_ack, key_done, key_result, busy
   );
endinterface

// File: rtl/sub_bytes_sched.sv
// Shared S-box scheduler: LANES registered lookups per beat, time-shared between
// round SubBytes and key SubWord. Define SUB_BYTES_SCHED_INV_EN to build the inverse tables.
module sub_bytes_sched #(
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   sub_bytes_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   localparam logic [3:0] RND_LAST = 4'(16 / LANES - 1);
   localparam logic [3:0] KEY_LAST = 4'(4 / LANES - 1);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r, s;
      r = 8'h01;
      s = x;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] i;
      i = gf_inv(x);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

`ifdef SUB_BYTES_SCHED_INV_EN
   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction
`endif

   state_t       state_p0;
   logic [3:0]   beat_p0;
   logic         key_p0;
   logic         last_key;
   logic [0:127] opnd_p0;
`ifdef SUB_BYTES_SCHED_INV_EN
   logic         inv_p0;
`endif
   logic         vld_p1;
   logic [3:0]   beat_p1;
   logic [7:0]   lane_in [LANES];
   logic [7:0]   lane_p1 [LANES];
   logic [0:127] rnd_res;
   logic [0:31]  key_res;
   logic         rnd_ack_q, rnd_done_q, key_ack_q, key_done_q, busy_q;
   logic         grant_rnd, grant_key;

   // On a tie, the port that did not win last time gets the grant.
   assign grant_rnd = bus.rnd_req && (!bus.key_req || last_key);
   assign grant_key = bus.key_req && !grant_rnd;

   // Stage p0: job control and operand select
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_p0   <= IDLE;
         beat_p0    <= 4'd0;
         key_p0     <= 1'b0;
         last_key   <= 1'b1;
         rnd_ack_q  <= 1'b0;
         key_ack_q  <= 1'b0;
         rnd_done_q <= 1'b0;
         key_done_q <= 1'b0;
         busy_q     <= 1'b0;
         vld_p1     <= 1'b0;
         beat_p1    <= 4'd0;
      end else begin
         rnd_ack_q  <= 1'b0;
         key_ack_q  <= 1'b0;
         rnd_done_q <= 1'b0;
         key_done_q <= 1'b0;
         vld_p1     <= (state_p0 == ISSUE);
         beat_p1    <= beat_p0;
         case (state_p0)
            IDLE: begin
               beat_p0 <= 4'd0;
               if (grant_rnd || grant_key) begin
                  key_p0    <= grant_key;
                  last_key  <= grant_key;
                  rnd_ack_q <= grant_rnd;
                  key_ack_q <= grant_key;
                  busy_q    <= 1'b1;
                  state_p0  <= ISSUE;
               end
            end
            ISSUE: begin
               beat_p0 <= beat_p0 + 4'd1;
               if (beat_p0 == (key_p0 ? KEY_LAST : RND_LAST)) state_p0 <= DRAIN;
            end
            DRAIN: begin
               rnd_done_q <= !key_p0;
               key_done_q <= key_p0;
               busy_q     <= 1'b0;
               state_p0   <= IDLE;
            end
            default: state_p0 <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_p0 == IDLE && (grant_rnd || grant_key)) begin
         opnd_p0 <= grant_rnd ? bus.rnd_state : {bus.key_word, 96'd0};
`ifdef SUB_BYTES_SCHED_INV_EN
         inv_p0  <= grant_rnd && bus.rnd_inv;
`endif
      end
   end

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_in[j] = opnd_p0[7'(8 * (int'(beat_p0) * LANES + j)) +: 8];
      end
   end

   // Stage p1: registered S-box lanes
   always_ff @(posedge clk) begin
      for (int j = 0; j < LANES; j++) begin
`ifdef SUB_BYTES_SCHED_INV_EN
         lane_p1[j] <= inv_p0 ? sbox_inv(lane_in[j]) : sbox_fwd(lane_in[j]);
`else
         lane_p1[j] <= sbox_fwd(lane_in[j]);
`endif
      end
   end

   // Stage p2: scatter lane outputs into the owning port's result
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rnd_res <= '0;
         key_res <= '0;
      end else if (vld_p1) begin
         for (int j = 0; j < LANES; j++) begin
            if (key_p0)
               key_res[5'(8 * ((int'(beat_p1) * LANES + j) % 4)) +: 8] <= lane_p1[j];
            else
               rnd_res[7'(8 * (int'(beat_p1) * LANES + j)) +: 8] <= lane_p1[j];
         end
      end
   end

   assign bus.rnd_ack    = rnd_ack_q;
   assign bus.rnd_done   = rnd_done_q;
   assign bus.rnd_result = rnd_res;
   assign bus.key_ack    = key_ack_q;
   assign bus.key_done   = key_done_q;
   assign bus.key_result = key_res;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Directed bench for sub_bytes_sched (LANES=4): table of jobs plus tie, reset and
// held-request sequences.
module tb_sub_bytes_sched;
   localparam int LANES   = 4;
   localparam int RND_LAT = 16 / LANES + 1;
   localparam int KEY_LAT = 4 / LANES + 1;

   typedef struct {
      logic         is_key;
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errs = 0;
   int   checks = 0;
   logic [127:0] trk_rnd = '0;
   logic [127:0] trk_key = '0;
   vec_t vecs [6];

   sub_bytes_sched_if bus ();

   sub_bytes_sched #(.LANES(LANES)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_done(input logic is_key, output int lat);
      lat = 0;
      while ((is_key ? bus.key_done : bus.rnd_done) !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_job(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      if (v.is_key) begin
         bus.key_word = v.din[31:0];
         bus.key_req  = 1'b1;
      end else begin
         bus.rnd_state = v.din;
         bus.rnd_inv   = v.inv;
         bus.rnd_req   = 1'b1;
      end
      @(negedge clk);
      check({tag, "_ack"}, v.is_key ? bus.key_ack : bus.rnd_ack, 1'b1);
      check({tag, "_busy"}, bus.busy, 1'b1);
      bus.key_req = 1'b0;
      bus.rnd_req = 1'b0;
      wait_done(v.is_key, lat);
      check({tag, "_latency"}, lat, v.is_key ? KEY_LAT : RND_LAT);
      check({tag, "_busy_at_done"}, bus.busy, 1'b0);
      if (v.is_key) begin
         check({tag, "_result"}, bus.key_result, v.dout);
         check({tag, "_rnd_kept"}, bus.rnd_result, trk_rnd);
         trk_key = v.dout;
      end else begin
         check({tag, "_result"}, bus.rnd_result, v.dout);
         check({tag, "_key_kept"}, bus.key_result, trk_key);
         trk_rnd = v.dout;
      end
   endtask

   initial begin
      int lat, nacks, first, second, dones;
      vecs[0] = '{1'b0, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0,
                  128'h63cab7040953d051cd60e0e7ba70e18c};
`ifdef SUB_BYTES_SCHED_INV_EN
      vecs[1] = '{1'b0, 1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c,
                  128'h00102030405060708090a0b0c0d0e0f0};
`else
      vecs[1] = '{1'b0, 1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c,
                  128'hfb74a9f201ed70d1bdd0e194f451f864};
`endif
      vecs[2] = '{1'b1, 1'b0, 128'hcf4f3c09, 128'h8a84eb01};
      vecs[3] = '{1'b0, 1'b0, 128'h0, 128'h63636363636363636363636363636363};
      vecs[4] = '{1'b0, 1'b0, {16{8'hff}}, {16{8'h16}}};
      vecs[5] = '{1'b1, 1'b0, 128'hffffffff, 128'h16161616};

      bus.rnd_req = 1'b0;
      bus.rnd_inv = 1'b0;
      bus.rnd_state = '0;
      bus.key_req = 1'b0;
      bus.key_word = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      check("reset_busy", bus.busy, 1'b0);
      check("reset_acks", {bus.rnd_ack, bus.key_ack}, 2'b00);
      check("reset_dones", {bus.rnd_done, bus.key_done}, 2'b00);
      check("reset_rnd_result", bus.rnd_result, 128'h0);
      check("reset_key_result", bus.key_result, 128'h0);

      // Tie straight out of reset: round wins, key follows after rnd_done.
      @(negedge clk);
      bus.rnd_state = vecs[0].din;
      bus.rnd_inv = 1'b0;
      bus.rnd_req = 1'b1;
      bus.key_word = 32'hcf4f3c09;
      bus.key_req = 1'b1;
      @(negedge clk);
      check("tie1_rnd_ack", bus.rnd_ack, 1'b1);
      check("tie1_key_no_ack", bus.key_ack, 1'b0);
      bus.rnd_req = 1'b0;
      wait_done(1'b0, lat);
      check("tie1_rnd_latency", lat, RND_LAT);
      check("tie1_key_waits", bus.key_ack, 1'b0);
      check("tie1_rnd_result", bus.rnd_result, vecs[0].dout);
      @(negedge clk);
      check("tie1_key_ack", bus.key_ack, 1'b1);
      bus.key_req = 1'b0;
      wait_done(1'b1, lat);
      check("tie1_key_latency", lat, KEY_LAT);
      check("tie1_key_result", bus.key_result, 128'h8a84eb01);
      trk_rnd = vecs[0].dout;
      trk_key = 128'h8a84eb01;

      for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("vec%0d", i));

      // Last grant was key (vec5); one round job flips it, then a tie favours key.
      run_job(vecs[3], "lone_rnd");
      @(negedge clk);
      bus.rnd_state = vecs[4].din;
      bus.rnd_req = 1'b1;
      bus.key_word = 32'hcf4f3c09;
      bus.key_req = 1'b1;
      @(negedge clk);
      check("tie2_key_ack", bus.key_ack, 1'b1);
      check("tie2_rnd_no_ack", bus.rnd_ack, 1'b0);
      bus.key_req = 1'b0;
      wait_done(1'b1, lat);
      check("tie2_key_result", bus.key_result, 128'h8a84eb01);
      @(negedge clk);
      check("tie2_rnd_ack", bus.rnd_ack, 1'b1);
      bus.rnd_req = 1'b0;
      wait_done(1'b0, lat);
      check("tie2_rnd_result", bus.rnd_result, vecs[4].dout);

      // Reset during the third ISSUE beat of a round job.
      @(negedge clk);
      bus.rnd_state = vecs[0].din;
      bus.rnd_req = 1'b1;
      @(negedge clk);
      bus.rnd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_rnd_result", bus.rnd_result, 128'h0);
      check("midrst_key_result", bus.key_result, 128'h0);
      check("midrst_flags", {bus.rnd_ack, bus.key_ack, bus.rnd_done, bus.key_done}, 4'h0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rnd_done === 1'b1) dones++;
      end
      check("midrst_no_done", dones, 0);
      trk_rnd = '0;
      trk_key = '0;
      run_job(vecs[0], "post_rst");

      // key_req held for six cycles: two jobs, acks three cycles apart.
      @(negedge clk);
      bus.key_word = 32'h0;
      bus.key_req = 1'b1;
      nacks = 0;
      first = 0;
      second = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (bus.key_ack === 1'b1) begin
            nacks++;
            if (nacks == 1) first = i;
            else second = i;
         end
      end
      bus.key_req = 1'b0;
      check("held_ack_count", nacks, 2);
      check("held_ack_gap", second - first, 3);
      check("held_key_done", bus.key_done, 1'b1);
      check("held_key_result", bus.key_result, 128'h63636363);
      @(negedge clk);
      check("held_no_third", {bus.key_ack, bus.busy}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
